usb_bus_bridge: RTL

Wishbone-style 32-bit slave that gives a soft CPU access to the USB core. It translates each CPU cycle into one of two accesses:
- a 16-bit CSR / EP-status access on the core's cyc/we/ack bus (variable latency), or
- a direct 32-bit access to the core's EP TX/RX buffer ports (fixed latency).
It sits between the SoC interconnect and the USB core. It adds a per-access timeout so a stalled core cannot hang the CPU.

---
 rtl/usb_bus_bridge_if.sv | 44 ++++
 rtl/usb_bus_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_bridge_if.sv
// Bridge bus bundle: CPU-side Wishbone-style slave signals, the USB core's
// 16-bit CSR/EPS bus, the 32-bit EP TX/RX buffer ports and the sticky
// timeout flag.
//   slave  : view taken by usb_bus_bridge
//   master : view taken by the SoC side (CPU, core, EP buffer)
interface usb_bus_bridge_if #(
  parameter int unsigned EPAW = 9
);
  // CPU side
  logic [15:0]     wb_addr;
  logic [31:0]     wb_wdata;
  logic            wb_we;
  logic            wb_cyc;
  logic [31:0]     wb_rdata;
  logic            wb_ack;
  // USB core CSR/EPS bus
  logic [15:0]     usb_bus_addr;
  logic [15:0]     usb_bus_din;
  logic [15:0]     usb_bus_dout;
  logic            usb_bus_cyc;
  logic            usb_bus_we;
  logic            usb_bus_ack;
  // EP buffer ports
  logic [EPAW-1:0] ep_tx_addr_0;
  logic [31:0]     ep_tx_data_0;
  logic            ep_tx_we_0;
  logic [EPAW-1:0] ep_rx_addr_0;
  logic            ep_rx_re_0;
  logic [31:0]     ep_rx_data_1;
  // Status
  logic            err_timeout;

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc, usb_bus_dout, usb_bus_ack, ep_rx_data_1,
    output wb_rdata, wb_ack, usb_bus_addr, usb_bus_din, usb_bus_cyc, usb_bus_we,
           ep_tx_addr_0, ep_tx_data_0, ep_tx_we_0, ep_rx_addr_0, ep_rx_re_0, err_timeout
  );

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc, usb_bus_dout, usb_bus_ack, ep_rx_data_1,
    input  wb_rdata, wb_ack, usb_bus_addr, usb_bus_din, usb_bus_cyc, usb_bus_we,
           ep_tx_addr_0, ep_tx_data_0, ep_tx_we_0, ep_rx_addr_0, ep_rx_re_0, err_timeout
  );
endinterface

// File: rtl/usb_bus_bridge.sv
// CPU-to-USB-core bridge. Each CPU cycle becomes either a 16-bit CSR/EPS
// access on the core's cyc/we/ack bus (variable latency, bounded by TIMEOUT)
// or a 32-bit access to the EP TX/RX buffer ports (fixed latency).
// Ports:
//   clk  : system clock (core and EP buffer share it)
//   rst  : asynchronous active-high reset
//   bus  : usb_bus_bridge_if.slave (CPU bus, core bus, EP ports, err_timeout)
// All outputs are registered; a DONE cycle separates accesses so the core
// always sees usb_bus_cyc low between them.
module usb_bus_bridge #(
  parameter logic [3:0]  ADDR_MSB = 4'h3,
  parameter int unsigned EPAW     = 9,
  parameter int unsigned TIMEOUT  = 63
) (
  input logic              clk,
  input logic              rst,
  usb_bus_bridge_if.slave  bus
);

  localparam logic [7:0] TimeoutM1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCsr, StEpr, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0]     wb_rdata_q, wb_rdata_d;
  logic            wb_ack_q, wb_ack_d;
  logic [15:0]     usb_addr_q, usb_addr_d;
  logic [15:0]     usb_din_q, usb_din_d;
  logic            usb_cyc_q, usb_cyc_d;
  logic            usb_we_q, usb_we_d;
  logic [EPAW-1:0] tx_addr_q, tx_addr_d;
  logic [31:0]     tx_data_q, tx_data_d;
  logic            tx_we_q, tx_we_d;
  logic [EPAW-1:0] rx_addr_q, rx_addr_d;
  logic            rx_re_q, rx_re_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  // EP writes need one extra cycle before wb_ack; DONE holds it here.
  logic            ack_pend_q, ack_pend_d;

  logic accept;
  logic timeout_hit;
  logic unused_addr_bits;

  assign accept      = (state_q == StIdle) && bus.wb_cyc && !wb_ack_q;
  assign timeout_hit = (cnt_q == TimeoutM1);
  // Upper window bits alias by design.
  assign unused_addr_bits = ^bus.wb_addr[14:12];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!bus.wb_addr[15]) begin
            state_d = StCsr;
          end else if (bus.wb_we) begin
            state_d = StDone;
          end else begin
            state_d = StEpr;
          end
        end
      end
      StCsr: begin
        if (bus.usb_bus_ack || timeout_hit) state_d = StDone;
      end
      StEpr: begin
        if (cnt_q[0]) state_d = StDone;
      end
      StDone: begin
        if (!ack_pend_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    wb_rdata_d = '0;
    wb_ack_d   = 1'b0;
    usb_addr_d = usb_addr_q;
    usb_din_d  = usb_din_q;
    usb_cyc_d  = usb_cyc_q;
    usb_we_d   = usb_we_q;
    tx_addr_d  = tx_addr_q;
    tx_data_d  = tx_data_q;
    tx_we_d    = 1'b0;
    rx_addr_d  = rx_addr_q;
    rx_re_d    = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    ack_pend_d = ack_pend_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          if (!bus.wb_addr[15]) begin
            usb_addr_d = {ADDR_MSB, bus.wb_addr[11:0]};
            usb_din_d  = bus.wb_wdata[15:0];
            usb_we_d   = bus.wb_we;
            usb_cyc_d  = 1'b1;
          end else if (bus.wb_we) begin
            tx_addr_d  = bus.wb_addr[EPAW-1:0];
            tx_data_d  = bus.wb_wdata;
            tx_we_d    = 1'b1;
            ack_pend_d = 1'b1;
          end else begin
            rx_addr_d = bus.wb_addr[EPAW-1:0];
            rx_re_d   = 1'b1;
          end
        end
      end
      StCsr: begin
        // A core ack on the timeout cycle still counts as normal completion.
        if (bus.usb_bus_ack) begin
          usb_cyc_d = 1'b0;
          wb_ack_d  = bus.wb_cyc;
          if (bus.wb_cyc && !usb_we_q) wb_rdata_d = {16'h0000, bus.usb_bus_dout};
        end else if (timeout_hit) begin
          usb_cyc_d = 1'b0;
          wb_ack_d  = bus.wb_cyc;
          err_d     = 1'b1;
          if (bus.wb_cyc && !usb_we_q) wb_rdata_d = 32'hFFFF_FFFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StEpr: begin
        // cnt_q[0] marks the cycle in which the buffer data is valid.
        if (cnt_q[0]) begin
          wb_ack_d = bus.wb_cyc;
          if (bus.wb_cyc) wb_rdata_d = bus.ep_rx_data_1;
        end else begin
          cnt_d = 8'd1;
        end
      end
      StDone: begin
        if (ack_pend_q) begin
          wb_ack_d   = bus.wb_cyc;
          ack_pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rdata_q <= '0;
      wb_ack_q   <= 1'b0;
      usb_addr_q <= '0;
      usb_din_q  <= '0;
      usb_cyc_q  <= 1'b0;
      usb_we_q   <= 1'b0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_we_q    <= 1'b0;
      rx_addr_q  <= '0;
      rx_re_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ack_pend_q <= 1'b0;
    end else begin
      wb_rdata_q <= wb_rdata_d;
      wb_ack_q   <= wb_ack_d;
      usb_addr_q <= usb_addr_d;
      usb_din_q  <= usb_din_d;
      usb_cyc_q  <= usb_cyc_d;
      usb_we_q   <= usb_we_d;
      tx_addr_q  <= tx_addr_d;
      tx_data_q  <= tx_data_d;
      tx_we_q    <= tx_we_d;
      rx_addr_q  <= rx_addr_d;
      rx_re_q    <= rx_re_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  assign bus.wb_rdata     = wb_rdata_q;
  assign bus.wb_ack       = wb_ack_q;
  assign bus.usb_bus_addr = usb_addr_q;
  assign bus.usb_bus_din  = usb_din_q;
  assign bus.usb_bus_cyc  = usb_cyc_q;
  assign bus.usb_bus_we   = usb_we_q;
  assign bus.ep_tx_addr_0 = tx_addr_q;
  assign bus.ep_tx_data_0 = tx_data_q;
  assign bus.ep_tx_we_0   = tx_we_q;
  assign bus.ep_rx_addr_0 = rx_addr_q;
  assign bus.ep_rx_re_0   = rx_re_q;
  assign bus.err_timeout  = err_q;

endmodule
